// File: rtl/nrzi_rx_if.sv
// Byte-side and line-side signals of the NRZI receive decoder.
// The slave modport is the decoder; the master modport is whoever drives the line and consumes words.
interface nrzi_rx_if #(
  parameter int DATA_W = 8
);
  logic              din;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              sync_found;
  logic              frame_done;
  logic              overrun;

  modport master (
    output din,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  sync_found,
    input  frame_done,
    input  overrun
  );

  modport slave (
    input  din,
    input  out_ready,
    output out_data,
    output out_valid,
    output sync_found,
    output frame_done,
    output overrun
  );
endinterface

// File: rtl/nrzi_rx_decoder.sv
// NRZI line receiver: transition decode, sync-word hunt, and fixed-length
// frame assembly into words presented on a valid/ready port.
module nrzi_rx_decoder #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD = 8'h7E,
  parameter int                FRAME_LEN = 4
) (
  input logic      clk,
  input logic      rst,
  nrzi_rx_if.slave bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic              sync1;
  logic              sync2;
  logic              prev;
  logic [0:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] nxt;
  logic [CW-1:0]     bit_cnt;
  logic [7:0]        word_cnt;
  logic              rx_bit;
  logic              word_done;
  logic              last_word;

  assign rx_bit    = sync2 ^ prev;
  assign nxt       = {rx_bit, shreg[DATA_W-1:1]};
  assign word_done = (state == RECV) && (bit_cnt == CW'(DATA_W - 1));
  assign last_word = (word_cnt == 8'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      prev           <= 1'b0;
      state          <= HUNT;
      shreg          <= '0;
      bit_cnt        <= '0;
      word_cnt       <= '0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.sync_found <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      sync1          <= bus.din;
      sync2          <= sync1;
      prev           <= sync2;
      bus.sync_found <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;
      case (state)
        HUNT: begin
          shreg <= nxt;
          if (nxt == SYNC_WORD) begin
            bus.sync_found <= 1'b1;
            bit_cnt        <= '0;
            word_cnt       <= '0;
            state          <= RECV;
          end
        end
        RECV: begin
          shreg <= nxt;
          if (word_done) begin
            bit_cnt       <= '0;
            bus.out_data  <= nxt;
            // a completed word always wins over a same-edge accept
            bus.out_valid <= 1'b1;
            bus.overrun   <= bus.out_valid && !bus.out_ready;
            if (last_word) begin
              bus.frame_done <= 1'b1;
              shreg          <= '0;
              word_cnt       <= '0;
              state          <= HUNT;
            end else begin
              word_cnt <= word_cnt + 8'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Randomized scoreboard bench for nrzi_rx_decoder driven by a toggle encoder.
// Expected events are produced from the decoded bit stream and checked per cycle.
module tb_nrzi_rx_decoder;
  localparam int         DW   = 8;
  localparam logic [7:0] SYNC = 8'h7E;
  localparam int         FL   = 4;

  typedef struct {
    int         at;
    bit         is_sync;
    logic [7:0] data;
    bit         last;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  nrzi_rx_if #(.DATA_W(DW)) bus ();

  nrzi_rx_decoder #(
    .DATA_W(DW), .SYNC_WORD(SYNC), .FRAME_LEN(FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   ecnt = 0;
  logic rdy_q = 1'b0;
  always @(posedge clk) begin
    ecnt  <= ecnt + 1;
    rdy_q <= bus.out_ready;
  end

  int  errors = 0;
  int  checks = 0;
  bit  started = 0;
  ev_t q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // reference model over the decoded bit stream
  bit   hunting = 1;
  bit   win[$];
  bit   fbits[$];
  int   wcount = 0;
  logic level = 1'b0;

  function automatic logic [7:0] pack8(bit b[$]);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = b[i];
    return v;
  endfunction

  task automatic model_reset();
    hunting = 1;
    win.delete();
    for (int i = 0; i < 8; i++) win.push_back(1'b0);
    fbits.delete();
    wcount = 0;
  endtask

  task automatic model_bit(bit b, int at);
    ev_t ev;
    if (hunting) begin
      win.push_back(b);
      void'(win.pop_front());
      if (pack8(win) == SYNC) begin
        ev.at = at; ev.is_sync = 1; ev.data = 0; ev.last = 0;
        q.push_back(ev);
        hunting = 0;
        fbits.delete();
        wcount = 0;
      end
    end else begin
      fbits.push_back(b);
      if (fbits.size() == 8) begin
        wcount++;
        ev.at = at; ev.is_sync = 0;
        ev.data = pack8(fbits); ev.last = (wcount == FL);
        q.push_back(ev);
        fbits.delete();
        if (ev.last) model_reset();
      end
    end
  endtask

  task automatic send_bit(bit b, logic rdy);
    @(negedge clk);
    level         = level ^ b;
    bus.din       = level;
    bus.out_ready = rdy;
    model_bit(b, ecnt + 3);
  endtask

  task automatic send_byte(logic [7:0] v, logic rdy);
    for (int i = 0; i < 8; i++) send_bit(v[i], rdy);
  endtask

  task automatic idle(int n, logic rdy);
    for (int i = 0; i < n; i++) send_bit(1'b0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst     = 1'b1;
    started = 1;
    q.delete();
    model_reset();
    level   = 1'b0;
    bus.din = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sync", bus.sync_found, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_data", bus.out_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: per-cycle comparison against the queued expectations
  bit         pending = 0;
  logic [7:0] exp_data = '0;
  always @(negedge clk) begin
    bit e_sync, e_fd, e_ovr, e_new;
    int e;
    if (started) begin
      if (rst) begin
        pending = 0;
        chk("in_rst_valid", bus.out_valid, 0);
        chk("in_rst_pulse", {bus.sync_found, bus.frame_done, bus.overrun}, 0);
      end else begin
        e = ecnt;
        e_sync = 0; e_fd = 0; e_ovr = 0; e_new = 0;
        while (q.size() > 0 && q[0].at < e) begin
          chk("missed_event", 32'(q[0].at), 32'(e));
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at == e && q[0].is_sync) begin
          e_sync = 1;
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at == e && !q[0].is_sync) begin
          e_new    = 1;
          exp_data = q[0].data;
          e_fd     = q[0].last;
          void'(q.pop_front());
        end
        if (e_new) begin
          e_ovr   = pending && !rdy_q;
          pending = 1;
        end else if (pending && rdy_q) begin
          pending = 0;
        end
        chk("sync_found", bus.sync_found, e_sync);
        chk("frame_done", bus.frame_done, e_fd);
        chk("overrun", bus.overrun, e_ovr);
        chk("out_valid", bus.out_valid, pending);
        if (pending) chk("out_data", bus.out_data, exp_data);
      end
    end
  end

  initial begin
    logic [7:0] frame [4];
    bus.din       = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    do_reset();
    idle(50, 1'b0);

    frame = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    send_byte(SYNC, 1'b1);
    for (int w = 0; w < 4; w++) send_byte(frame[w], 1'b1);
    idle(12, 1'b1);

    send_byte(SYNC, 1'b0);
    for (int w = 0; w < 4; w++) send_byte(frame[w], 1'b0);
    idle(10, 1'b0);
    idle(4, 1'b1);

    // ready is seen high exactly on the edge that completes word 2
    send_byte(SYNC, 1'b0);
    for (int i = 0; i < 32; i++)
      send_bit(frame[i / 8][i % 8], (i == 17) ? 1'b1 : 1'b0);
    idle(6, 1'b0);
    idle(4, 1'b1);

    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    idle(5, 1'b1);
    send_byte(SYNC, 1'b1);
    for (int w = 0; w < 4; w++) send_byte(8'($urandom), 1'b1);
    idle(8, 1'b1);

    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++)
        send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send_byte(SYNC, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 8 * FL; i++)
        send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    idle(30, 1'b1);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
